pipeline_hazard_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Decides every cycle which pipeline registers (PC, IF/ID, ID/EX, EX/MEM) load, hold, or take a bubble.
- Handles three events:
  - load-use hazards the forwarding unit cannot cover;
  - taken-branch flush penalty;
  - multi-cycle data-memory waits, using a req/ready handshake.
- Also keeps saturating stall/flush performance counters and a sticky memory-timeout error flag.

---
 rtl/pipeline_hazard_controller_pkg.sv | 15 +
 rtl/pipeline_hazard_controller_if.sv | 36 +++
 rtl/pipeline_hazard_controller_sat_counter.sv | 29 ++
 rtl/pipeline_hazard_controller.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam int unsigned DEF_FLUSH_CYCLES = 1;
    localparam int unsigned DEF_MEM_TIMEOUT  = 64;
    localparam int unsigned WAIT_W           = 8;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Decode/EX/MEM status in, pipeline register enables and status out.
interface pipeline_hazard_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_uses_rt;
    logic             Exe_Memread;
    logic [4:0]       Exe_rd;
    logic             branch_taken_Exe;
    logic             Mem_req;
    logic             mem_ready;
    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_write;
    logic             IDEX_bubble;
    logic             EXMEM_write;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic             mem_error;

    modport master (
        output ID_rs, ID_rt, ID_uses_rt, Exe_Memread, Exe_rd,
               branch_taken_Exe, Mem_req, mem_ready,
        input  PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble,
               EXMEM_write, stall_cycles, flush_count, mem_error
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rt, Exe_Memread, Exe_rd,
               branch_taken_Exe, Mem_req, mem_ready,
        output PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble,
               EXMEM_write, stall_cycles, flush_count, mem_error
    );
endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (inc_i && (count_q != '1))
            count_d = count_q + WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: memory freeze > branch flush > load-use stall > normal.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int unsigned MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W        = 16
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_hazard_controller_if.slave hz
);
    localparam logic [3:0]        FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_AT   = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q, state_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_busy, load_use, stall_inc, flush_inc;
    logic              pc_w, ifid_w, ifid_fl, idex_w, idex_b, exmem_w;

    assign mem_busy = hz.Mem_req && !hz.mem_ready;
    assign load_use = hz.Exe_Memread && (hz.Exe_rd != REG_ZERO) &&
                      ((hz.Exe_rd == hz.ID_rs) ||
                       (hz.ID_uses_rt && (hz.Exe_rd == hz.ID_rt)));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        ifid_fl     = 1'b0;
        idex_w      = 1'b1;
        idex_b      = 1'b0;
        exmem_w     = 1'b1;
        if (mem_busy) begin
            pc_w      = 1'b0;
            ifid_w    = 1'b0;
            idex_w    = 1'b0;
            exmem_w   = 1'b0;
            stall_inc = 1'b1;
            if (state_q == RUN)
                state_d = MEM_WAIT;
        end else if (state_q == FLUSH) begin
            ifid_fl     = 1'b1;
            idex_b      = 1'b1;
            flush_cnt_d = flush_cnt_q - 4'd1;
            if (flush_cnt_q == 4'd1)
                state_d = RUN;
        end else begin
            // MEM_WAIT released this cycle behaves exactly like RUN
            state_d = RUN;
            if (hz.branch_taken_Exe) begin
                ifid_fl   = 1'b1;
                idex_b    = 1'b1;
                flush_inc = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_RELOAD;
                end
            end else if (load_use) begin
                pc_w      = 1'b0;
                ifid_w    = 1'b0;
                idex_b    = 1'b1;
                stall_inc = 1'b1;
            end
        end
        if (reset) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            ifid_fl = 1'b1;
            idex_b  = 1'b1;
        end
    end

    assign mem_error_d = mem_error_q || (mem_busy && (wait_cnt >= TIMEOUT_AT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (mem_busy),
        .clear_i (!mem_busy),
        .count_o (wait_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (stall_inc),
        .clear_i (1'b0),
        .count_o (hz.stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (flush_inc),
        .clear_i (1'b0),
        .count_o (hz.flush_count)
    );

    assign hz.PC_write    = pc_w;
    assign hz.IFID_write  = ifid_w;
    assign hz.IFID_flush  = ifid_fl;
    assign hz.IDEX_write  = idex_w;
    assign hz.IDEX_bubble = idex_b;
    assign hz.EXMEM_write = exmem_w;
    assign hz.mem_error   = mem_error_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller against a cycle-level behavioural model.
module tb_pipeline_hazard_controller;
    localparam int unsigned CW  = 6;
    localparam int unsigned FC  = 2;
    localparam int unsigned TO  = 4;
    localparam int          SAT = (1 << CW) - 1;

    // Output vector order: {PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_write}
    localparam logic [5:0] O_RESET  = 6'b001010;
    localparam logic [5:0] O_NORMAL = 6'b110101;
    localparam logic [5:0] O_FREEZE = 6'b000000;
    localparam logic [5:0] O_STALL  = 6'b000111;
    localparam logic [5:0] O_BRANCH = 6'b101011;
    localparam logic [5:0] M_ALL    = 6'b111111;
    localparam logic [5:0] M_BRANCH = 6'b101011;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       ut;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    int         m_pending, m_busy_len, m_stalls, m_flushes;
    logic       m_err;
    logic [5:0] e_o, e_m;

    pipeline_hazard_controller_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_controller #(
        .FLUSH_CYCLES (FC),
        .MEM_TIMEOUT  (TO),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t busy_s(input logic rdy);
        stim_t s;
        s = '0;
        s.req = 1'b1;
        s.rdy = rdy;
        return s;
    endfunction

    function automatic logic [5:0] outs();
        return {hz.PC_write, hz.IFID_write, hz.IFID_flush,
                hz.IDEX_write, hz.IDEX_bubble, hz.EXMEM_write};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic apply(input stim_t s);
        hz.ID_rs            = s.rs;
        hz.ID_rt            = s.rt;
        hz.ID_uses_rt       = s.ut;
        hz.Exe_Memread      = s.mr;
        hz.Exe_rd           = s.rd;
        hz.branch_taken_Exe = s.br;
        hz.Mem_req          = s.req;
        hz.mem_ready        = s.rdy;
    endtask

    function automatic void model_reset();
        m_pending  = 0;
        m_busy_len = 0;
        m_stalls   = 0;
        m_flushes  = 0;
        m_err      = 1'b0;
    endfunction

    // One pipeline cycle: sets expected outputs, then advances bubble/wait bookkeeping.
    function automatic void model_step(input stim_t s);
        logic busy, hazard;
        busy   = s.req && !s.rdy;
        hazard = s.mr && (s.rd != 5'd0) && (s.rd == s.rs || (s.ut && s.rd == s.rt));
        e_m = M_ALL;
        if (busy) begin
            e_o        = O_FREEZE;
            m_stalls   = sat_inc(m_stalls);
            m_busy_len = m_busy_len + 1;
            if (m_busy_len >= TO) m_err = 1'b1;
        end else begin
            m_busy_len = 0;
            if (m_pending > 0) begin
                e_o = O_BRANCH; e_m = M_BRANCH;
                m_pending = m_pending - 1;
            end else if (s.br) begin
                e_o = O_BRANCH; e_m = M_BRANCH;
                m_flushes = sat_inc(m_flushes);
                m_pending = FC - 1;
            end else if (hazard) begin
                e_o = O_STALL;
                m_stalls = sat_inc(m_stalls);
            end else begin
                e_o = O_NORMAL;
            end
        end
    endfunction

    task automatic do_reset();
        apply(quiet());
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        s = quiet();
        s.br = 1'b1; s.req = 1'b1; s.mr = 1'b1; s.rd = 5'd2; s.rs = 5'd2;
        apply(s);
        reset = 1'b1;
        #12;
        total++;
        if (outs() !== O_RESET) begin
            bad++; $display("FAIL reset_outs got=%b want=%b", outs(), O_RESET);
        end
        total++;
        if ({hz.stall_cycles, hz.flush_count, hz.mem_error} !== {CW'(0), CW'(0), 1'b0}) begin
            bad++; $display("FAIL reset_state got=%0d/%0d/%b want=0/0/0",
                            hz.stall_cycles, hz.flush_count, hz.mem_error);
        end
        @(negedge clk);
        apply(quiet());
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        stim_t q[$];
        stim_t s;
        int    nstall;
        do_reset();
        s = quiet(); s.mr = 1'b1; s.rd = 5'd5; s.rs = 5'd5;
        q = '{s, quiet(), quiet()};
        nstall = 0;
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            model_step(q[i]);
            total++;
            if ((outs() & e_m) !== (e_o & e_m)) begin
                bad++; $display("FAIL load_use_outs cyc=%0d got=%b want=%b", i, outs(), e_o);
            end
            if (!hz.PC_write && !hz.IFID_write && hz.IDEX_bubble) nstall++;
            @(posedge clk);
            #1;
        end
        total++;
        if (nstall !== 1) begin
            bad++; $display("FAIL load_use_len got=%0d want=1", nstall);
        end
        total++;
        if (hz.stall_cycles !== CW'(1)) begin
            bad++; $display("FAIL load_use_cnt got=%0d want=1", hz.stall_cycles);
        end
    endtask

    task automatic test_zero_reg();
        stim_t q[$];
        stim_t a, b, c;
        do_reset();
        a = quiet(); a.mr = 1'b1; a.rd = 5'd0; a.rs = 5'd0;
        b = quiet(); b.mr = 1'b1; b.rd = 5'd7; b.rt = 5'd7; b.rs = 5'd1; b.ut = 1'b0;
        c = b;       c.ut = 1'b1;
        q = '{a, b, c, quiet()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            model_step(q[i]);
            total++;
            if ((outs() & e_m) !== (e_o & e_m)) begin
                bad++; $display("FAIL zero_reg_outs cyc=%0d got=%b want=%b", i, outs(), e_o);
            end
            @(posedge clk);
            #1;
            total++;
            if ({hz.stall_cycles, hz.flush_count} !== {CW'(m_stalls), CW'(m_flushes)}) begin
                bad++; $display("FAIL zero_reg_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i,
                                hz.stall_cycles, hz.flush_count, m_stalls, m_flushes);
            end
        end
    endtask

    task automatic test_branch();
        stim_t q[$];
        stim_t s;
        int    nfl, first, last;
        do_reset();
        s = quiet(); s.br = 1'b1;
        q = '{s, quiet(), quiet(), quiet(), s, s, quiet(), quiet()};
        nfl = 0; first = -1; last = -1;
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            model_step(q[i]);
            total++;
            if ((outs() & e_m) !== (e_o & e_m)) begin
                bad++; $display("FAIL branch_outs cyc=%0d got=%b want=%b", i, outs(), e_o);
            end
            if (i < 4 && hz.PC_write && hz.IFID_flush && hz.IDEX_bubble) begin
                nfl++;
                if (first < 0) first = i;
                last = i;
            end
            @(posedge clk);
            #1;
            if (i == 3) begin
                total++;
                if (nfl !== 2 || (last - first) !== 1 || hz.flush_count !== CW'(1)) begin
                    bad++; $display("FAIL branch_single got=%0d cycles span=%0d cnt=%0d want=2 span=1 cnt=1",
                                    nfl, last - first, hz.flush_count);
                end
            end
        end
        total++;
        if (hz.flush_count !== CW'(2)) begin
            bad++; $display("FAIL branch_in_flush_ignored got=%0d want=2", hz.flush_count);
        end
    endtask

    task automatic test_mem_wait();
        stim_t q[$];
        int    nfrz;
        do_reset();
        q = '{busy_s(1'b0), busy_s(1'b0), busy_s(1'b0), busy_s(1'b1), quiet()};
        nfrz = 0;
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            model_step(q[i]);
            total++;
            if ((outs() & e_m) !== (e_o & e_m)) begin
                bad++; $display("FAIL mem_wait_outs cyc=%0d got=%b want=%b", i, outs(), e_o);
            end
            if (!hz.PC_write && !hz.IFID_write && !hz.IDEX_write && !hz.EXMEM_write) nfrz++;
            @(posedge clk);
            #1;
        end
        total++;
        if (nfrz !== 3 || hz.stall_cycles !== CW'(3) || hz.mem_error !== 1'b0) begin
            bad++; $display("FAIL mem_wait_summary got=%0d/%0d/%b want=3/3/0",
                            nfrz, hz.stall_cycles, hz.mem_error);
        end
    endtask

    task automatic test_timeout();
        stim_t q[$];
        do_reset();
        q = '{busy_s(1'b0), busy_s(1'b0), busy_s(1'b0), busy_s(1'b0), busy_s(1'b0),
              busy_s(1'b0), busy_s(1'b1), quiet(), quiet()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            model_step(q[i]);
            @(posedge clk);
            #1;
            total++;
            if (hz.mem_error !== ((i >= 3) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL timeout_flag busy_edge=%0d got=%b want=%b",
                                i + 1, hz.mem_error, (i >= 3));
            end
        end
        do_reset();
        total++;
        if (hz.mem_error !== 1'b0) begin
            bad++; $display("FAIL timeout_clear got=%b want=0", hz.mem_error);
        end
    endtask

    task automatic test_simultaneous();
        stim_t q[$];
        stim_t s, r;
        do_reset();
        s = quiet(); s.mr = 1'b1; s.rd = 5'd3; s.rs = 5'd3; s.br = 1'b1; s.req = 1'b1;
        r = s;       r.rdy = 1'b1;
        q = '{s, s, r, quiet(), quiet()};
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            model_step(q[i]);
            total++;
            if ((outs() & e_m) !== (e_o & e_m)) begin
                bad++; $display("FAIL simul_outs cyc=%0d got=%b want=%b", i, outs(), e_o);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (hz.flush_count !== CW'(1) || hz.stall_cycles !== CW'(2)) begin
            bad++; $display("FAIL simul_cnt got=%0d/%0d want=1/2", hz.flush_count, hz.stall_cycles);
        end
    endtask

    task automatic test_reset_in_flush();
        stim_t s;
        do_reset();
        s = quiet(); s.br = 1'b1;
        apply(s);
        @(negedge clk);
        model_step(s);
        @(posedge clk);
        #1;
        apply(quiet());
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (outs() !== O_RESET || hz.flush_count !== CW'(0) || hz.stall_cycles !== CW'(0)) begin
            bad++; $display("FAIL flush_reset got=%b/%0d/%0d want=%b/0/0",
                            outs(), hz.flush_count, hz.stall_cycles, O_RESET);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (outs() !== O_NORMAL) begin
            bad++; $display("FAIL flush_reset_run got=%b want=%b", outs(), O_NORMAL);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 70; i++) begin
            apply(busy_s(1'b0));
            @(negedge clk);
            model_step(busy_s(1'b0));
            @(posedge clk);
            #1;
        end
        total++;
        if (hz.stall_cycles !== CW'(SAT)) begin
            bad++; $display("FAIL stall_saturate got=%0d want=%0d", hz.stall_cycles, SAT);
        end
    endtask

    task automatic test_random();
        stim_t s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s     = quiet();
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.ut  = 1'($urandom_range(0, 1));
            s.mr  = ($urandom_range(0, 99) < 35);
            s.br  = ($urandom_range(0, 99) < 15);
            s.req = ($urandom_range(0, 99) < 30);
            s.rdy = ($urandom_range(0, 99) < 50);
            apply(s);
            @(negedge clk);
            model_step(s);
            total++;
            if ((outs() & e_m) !== (e_o & e_m)) begin
                bad++; $display("FAIL random_outs cyc=%0d got=%b want=%b", i, outs(), e_o);
            end
            @(posedge clk);
            #1;
            total++;
            if ({hz.stall_cycles, hz.flush_count, hz.mem_error} !==
                {CW'(m_stalls), CW'(m_flushes), m_err}) begin
                bad++; $display("FAIL random_state cyc=%0d got=%0d/%0d/%b want=%0d/%0d/%b", i,
                                hz.stall_cycles, hz.flush_count, hz.mem_error,
                                m_stalls, m_flushes, m_err);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        model_reset();
        apply(quiet());
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_simultaneous();
        test_reset_in_flush();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
